// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: latches the execute payload, captures SRAM read data, aligns and extends loads
module mem_stage #(
  parameter int EXE_TO_MEM_LEN = 109,
  parameter int MEM_TO_WB_LEN  = 70,
  parameter int MEM_RF_LEN     = 38
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
  input  logic                      EXE_to_MEM_valid,
  output logic                      MEM_allowin,
  input  logic [31:0]               data_sram_rdata,
  output logic [MEM_TO_WB_LEN-1:0]  MEM_to_WB_BUS,
  output logic                      MEM_to_WB_valid,
  input  logic                      WB_allowin,
  output logic [MEM_RF_LEN-1:0]     MEM_RF_BUS
);

  logic                      mem_valid_q, mem_valid_d;
  logic [EXE_TO_MEM_LEN-1:0] bus_q, bus_d;
  logic                      first_cycle_q, first_cycle_d;
  logic [31:0]               rdata_buf_q, rdata_buf_d;

  logic        mem_ready_go;
  logic        accept;
  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result;
  logic [31:0] mem_sum;
  logic        mem_en;
  logic [4:0]  load_op;
  logic        rfrom_mem;
  logic [1:0]  offset;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] final_result;
  logic        unused_fields;

  assign {pc, gr_we, dest, exe_result, mem_sum, mem_en, load_op, rfrom_mem} = bus_q;
  assign unused_fields = ^{mem_sum, mem_en};
  assign offset        = exe_result[1:0];

  assign mem_ready_go    = 1'b1;
  assign MEM_allowin     = !mem_valid_q || (mem_ready_go && WB_allowin);
  assign MEM_to_WB_valid = mem_valid_q && mem_ready_go;
  assign accept          = EXE_to_MEM_valid && MEM_allowin;

  always_comb begin
    mem_valid_d   = MEM_allowin ? EXE_to_MEM_valid : mem_valid_q;
    bus_d         = accept ? EXE_to_MEM_BUS : bus_q;
    first_cycle_d = accept;
    // The SRAM word is only valid in the first cycle; keep it for stalled cycles.
    rdata_buf_d   = first_cycle_q ? data_sram_rdata : rdata_buf_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q   <= 1'b0;
      bus_q         <= '0;
      first_cycle_q <= 1'b0;
      rdata_buf_q   <= 32'd0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      bus_q         <= bus_d;
      first_cycle_q <= first_cycle_d;
      rdata_buf_q   <= rdata_buf_d;
    end
  end

  assign load_word = first_cycle_q ? data_sram_rdata : rdata_buf_q;

  always_comb begin
    load_byte = 8'd0;
    case (offset)
      2'd0: load_byte = load_word[7:0];
      2'd1: load_byte = load_word[15:8];
      2'd2: load_byte = load_word[23:16];
      2'd3: load_byte = load_word[31:24];
      default: load_byte = load_word[7:0];
    endcase
    load_half = offset[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    load_value = load_word;
    case (load_op)
      5'b10000: load_value = {{24{load_byte[7]}}, load_byte};
      5'b01000: load_value = {{16{load_half[15]}}, load_half};
      5'b00100: load_value = load_word;
      5'b00010: load_value = {24'd0, load_byte};
      5'b00001: load_value = {16'd0, load_half};
      default:  load_value = load_word;
    endcase
    final_result = rfrom_mem ? load_value : exe_result;
  end

  assign MEM_to_WB_BUS = {pc, gr_we, dest, final_result};
  assign MEM_RF_BUS    = {{5{gr_we & mem_valid_q}} & dest, rfrom_mem & mem_valid_q, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized checks of mem_stage against a field-level load model
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic [108:0] exe_bus;
  logic         exe_valid;
  logic         mem_allowin;
  logic [31:0]  rdata;
  logic [69:0]  wb_bus;
  logic         wb_valid;
  logic         wb_allowin;
  logic [37:0]  rf_bus;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .EXE_to_MEM_BUS   (exe_bus),
    .EXE_to_MEM_valid (exe_valid),
    .MEM_allowin      (mem_allowin),
    .data_sram_rdata  (rdata),
    .MEM_to_WB_BUS    (wb_bus),
    .MEM_to_WB_valid  (wb_valid),
    .WB_allowin       (wb_allowin),
    .MEM_RF_BUS       (rf_bus)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP_B = 5'b10000, OP_H = 5'b01000, OP_W = 5'b00100,
                         OP_BU = 5'b00010, OP_HU = 5'b00001;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [108:0] mk(input logic [31:0] pc, input logic gw, input logic [4:0] d,
                                      input logic [31:0] er, input logic [4:0] lop, input logic rm);
    return {pc, gw, d, er, er + 32'd4, rm | (lop == 5'd0 ? 1'b1 : 1'b0), lop, rm};
  endfunction

  // Expected result from the load rules: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_final(input logic [31:0] er, input logic [4:0] lop,
                                            input logic rm, input logic [31:0] w);
    logic [31:0] b, h;
    int off;
    off = int'(er[1:0]);
    b = (w >> (8 * off)) & 32'h0000_00ff;
    h = (er[1] ? (w >> 16) : w) & 32'h0000_ffff;
    if (!rm) return er;
    case (lop)
      OP_B:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      OP_H:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      OP_BU:   return b;
      OP_HU:   return h;
      default: return w;
    endcase
  endfunction

  task automatic do_load(input string tag, input logic [108:0] bus, input logic [31:0] rd,
                         input logic [31:0] exp);
    exe_bus = bus; exe_valid = 1'b1; wb_allowin = 1'b1;
    tick();
    exe_valid = 1'b0; rdata = rd;
    #1;
    check({tag, "_valid"}, 128'(wb_valid), 128'(1'b1));
    check({tag, "_result"}, 128'(wb_bus[31:0]), 128'(exp));
    tick();
  endtask

  logic [108:0] bb_bus [0:8];
  logic [31:0]  bb_rd  [0:7];

  logic         m_valid;
  logic [108:0] m_bus;
  logic [31:0]  m_word;
  logic         acc;
  logic [31:0]  m_fin;
  logic [4:0]   lop;
  logic [4:0]   ops [0:5];

  initial begin
    ops[0] = OP_B; ops[1] = OP_H; ops[2] = OP_W; ops[3] = OP_BU; ops[4] = OP_HU; ops[5] = 5'd0;
    resetn = 1'b0; exe_valid = 1'b0; exe_bus = '0; rdata = 32'h5A5A_5A5A; wb_allowin = 1'b1;
    tick(); tick();
    check("rst_valid", 128'(wb_valid), 128'(1'b0));
    check("rst_allowin", 128'(mem_allowin), 128'(1'b1));
    check("rst_rf", 128'(rf_bus), 128'(0));
    resetn = 1'b1;
    tick();

    exe_bus = mk(32'h1c00_0000, 1'b1, 5'd4, 32'h0000_1000, OP_W, 1'b1); exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0; rdata = 32'hDEAD_BEEF;
    #1;
    check("ldw_valid", 128'(wb_valid), 128'(1'b1));
    check("ldw_result", 128'(wb_bus[31:0]), 128'(32'hDEAD_BEEF));
    check("ldw_rf_from_mem", 128'(rf_bus[32]), 128'(1'b1));
    check("ldw_rf_dest", 128'(rf_bus[37:33]), 128'(5'd4));
    tick();

    do_load("ldb_off3", mk(32'h10, 1'b1, 5'd1, 32'h2003, OP_B, 1'b1), 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("ldbu_off3", mk(32'h14, 1'b1, 5'd2, 32'h2003, OP_BU, 1'b1), 32'h80FF_1234, 32'h0000_0080);
    do_load("ldh_off2", mk(32'h18, 1'b1, 5'd3, 32'h2002, OP_H, 1'b1), 32'h80FF_1234, 32'hFFFF_80FF);
    do_load("ldhu_off0", mk(32'h1c, 1'b1, 5'd4, 32'h2000, OP_HU, 1'b1), 32'h80FF_1234, 32'h0000_1234);
    do_load("ldb_off1", mk(32'h20, 1'b1, 5'd5, 32'h2001, OP_B, 1'b1), 32'h80FF_1234, 32'h0000_0012);

    exe_bus = mk(32'h30, 1'b1, 5'd9, 32'h3000, OP_W, 1'b1); exe_valid = 1'b1; wb_allowin = 1'b1;
    tick();
    exe_valid = 1'b0; rdata = 32'h1111_1111; wb_allowin = 1'b0;
    #1;
    check("stall_first", 128'(wb_bus[31:0]), 128'(32'h1111_1111));
    for (int i = 0; i < 3; i++) begin
      tick();
      rdata = 32'h2222_2222;
      #1;
      check("stall_hold", 128'(wb_bus[31:0]), 128'(32'h1111_1111));
      check("stall_allowin", 128'(mem_allowin), 128'(1'b0));
      check("stall_valid", 128'(wb_valid), 128'(1'b1));
    end
    wb_allowin = 1'b1;
    #1;
    check("stall_release_allowin", 128'(mem_allowin), 128'(1'b1));
    tick();
    check("stall_drained", 128'(wb_valid), 128'(1'b0));

    exe_bus = mk(32'h40, 1'b1, 5'd7, 32'h0000_0005, 5'd0, 1'b0); exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    #1;
    check("alu_result", 128'(wb_bus[31:0]), 128'(32'h5));
    check("alu_rf_dest", 128'(rf_bus[37:33]), 128'(5'd7));
    check("alu_rf_from_mem", 128'(rf_bus[32]), 128'(1'b0));
    tick();
    check("alu_gone_dest", 128'(rf_bus[37:33]), 128'(5'd0));
    check("alu_gone_valid", 128'(wb_valid), 128'(1'b0));

    for (int i = 0; i < 9; i++)
      bb_bus[i] = mk($urandom, 1'b1, 5'($urandom), $urandom, ops[i % 5], 1'b1);
    for (int i = 0; i < 8; i++) bb_rd[i] = $urandom;
    exe_bus = bb_bus[0]; exe_valid = 1'b1; wb_allowin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      rdata = bb_rd[i];
      if (i < 7) exe_bus = bb_bus[i+1]; else exe_valid = 1'b0;
      #1;
      check("b2b_valid", 128'(wb_valid), 128'(1'b1));
      check("b2b_first", 128'(dut.first_cycle_q), 128'(1'b1));
      check("b2b_result", 128'(wb_bus[31:0]),
            128'(ref_final(bb_bus[i][70:39], bb_bus[i][5:1], bb_bus[i][0], bb_rd[i])));
    end
    tick();

    exe_bus = mk(32'h50, 1'b1, 5'd11, 32'h4000, OP_W, 1'b1); exe_valid = 1'b1; wb_allowin = 1'b0;
    tick();
    exe_valid = 1'b0; rdata = 32'hCAFE_F00D;
    tick(); tick();
    resetn = 1'b0;
    tick();
    check("rstmid_valid", 128'(wb_valid), 128'(1'b0));
    check("rstmid_rf", 128'(rf_bus), 128'(0));
    check("rstmid_allowin", 128'(mem_allowin), 128'(1'b1));
    check("rstmid_buf", 128'(dut.rdata_buf_q), 128'(0));

    resetn = 1'b1; wb_allowin = 1'b1; exe_valid = 1'b0;
    m_valid = 1'b0; m_bus = '0; m_word = 32'd0;
    for (int n = 0; n < 400; n++) begin
      acc = exe_valid && (!m_valid || wb_allowin);
      if (!m_valid || wb_allowin) m_valid = exe_valid;
      if (acc) m_bus = exe_bus;
      tick();
      rdata = $urandom;
      if (acc) m_word = rdata;
      wb_allowin = ($urandom_range(0, 3) != 0);
      exe_valid  = ($urandom_range(0, 2) != 0);
      lop = ops[$urandom_range(0, 5)];
      exe_bus = mk($urandom, 1'($urandom), 5'($urandom), $urandom, lop, (lop != 5'd0) && ($urandom_range(0, 5) != 0));
      #1;
      m_fin = ref_final(m_bus[70:39], m_bus[5:1], m_bus[0], m_word);
      check("rnd_valid", 128'(wb_valid), 128'(m_valid));
      check("rnd_allowin", 128'(mem_allowin), 128'(!m_valid || wb_allowin));
      check("rnd_wb_bus", 128'(wb_bus), 128'({m_bus[108:71], m_fin}));
      check("rnd_rf_bus", 128'(rf_bus),
            128'({m_bus[76] && m_valid ? m_bus[75:71] : 5'd0, m_bus[0] & m_valid, m_fin}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the writeback stage.
- Latches the execute-to-memory bus and captures synchronous data-SRAM read data.
- Performs load byte/halfword selection and sign/zero extension.
- Forwards the final result to writeback and to the decode-stage bypass/hazard logic.
- Read data can still be used when writeback stalls, because the returned word is buffered internally.

Parameters:
- EXE_TO_MEM_LEN, 109, width of incoming bus {pc[31:0], gr_we, dest[4:0], exe_result[31:0], mem_sum[31:0], mem_en, load_op[4:0], rfrom_mem}, MSB first.
- MEM_TO_WB_LEN, 70, width of outgoing bus {pc[31:0], gr_we, dest[4:0], final_result[31:0]}.
- MEM_RF_LEN, 38, width of bypass bus {dest[4:0], rfrom_mem, final_result[31:0]}.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- EXE_to_MEM_BUS  in  EXE_TO_MEM_LEN  payload from execute.
- EXE_to_MEM_valid  in  1  execute payload valid.
- MEM_allowin  out  1  stage can accept a payload this cycle.
- data_sram_rdata  in  32  SRAM read word; valid exactly one cycle after the request cycle.
- MEM_to_WB_BUS  out  MEM_TO_WB_LEN  payload to writeback.
- MEM_to_WB_valid  out  1  payload to writeback valid.
- WB_allowin  in  1  writeback can accept.
- MEM_RF_BUS  out  MEM_RF_LEN  bypass/hazard info to decode.

Behaviour:
- Interface: reset is resetn, synchronous, active-low; clock is clk.
- Handshake:
  - MEM_ready_go = 1 always.
  - MEM_allowin = !MEM_valid || WB_allowin.
  - MEM_to_WB_valid = MEM_valid.
  - MEM_valid <= EXE_to_MEM_valid when MEM_allowin.
  - Bus register loads only on EXE_to_MEM_valid && MEM_allowin; otherwise it holds.
- Reset:
  - MEM_valid = 0, bus register = 0, first_cycle = 0, rdata_buf = 0.
  - Outputs therefore: MEM_to_WB_valid 0, MEM_RF_BUS dest field 0, MEM_allowin 1.
- Read-data capture:
  - first_cycle <= 1 when a payload is accepted; otherwise 0.
  - In the first cycle, the load word is data_sram_rdata; rdata_buf <= data_sram_rdata.
  - In later (stalled) cycles, the load word is rdata_buf. The SRAM output may change while stalled because execute keeps reading.
  - A back-to-back accept re-asserts first_cycle for the new payload.
- load_op encoding: bit4 LD_B, bit3 LD_H, bit2 LD_W, bit1 LD_BU, bit0 LD_HU; one-hot or zero.
- Byte lane select uses offset = exe_result[1:0]:
  - Byte = word[8*offset+7 : 8*offset].
  - Halfword = offset[1] ? word[31:16] : word[15:0].
- Extension:
  - LD_B / LD_H sign-extend.
  - LD_BU / LD_HU zero-extend.
  - LD_W passes the word unchanged.
  - Misaligned halfwords/words are not checked; offset bit0 is ignored for halfwords and bits[1:0] for words.
- Result: final_result = rfrom_mem ? load_value : exe_result. Stores (mem_en && !rfrom_mem) pass exe_result through.
- MEM_RF_BUS:
  - dest field = {5{gr_we & MEM_valid}} & dest.
  - rfrom_mem field = rfrom_mem & MEM_valid.
  - Combinational from stage state and data_sram_rdata, so it is valid in the first cycle.
- MEM_to_WB_BUS is combinational from the bus register and the load value.
- Simultaneous accept and WB drain: the old payload leaves and the new one enters in the same edge.
- Reset mid-load: the payload is dropped and the buffered word is discarded.
- No combinational path from WB_allowin to the bus outputs; the only such path is to MEM_allowin.

Test Plan:
- ld.w, exe_result=0x1000, rdata=0xDEADBEEF, WB_allowin=1 -> next cycle MEM_to_WB_valid=1 and final_result=0xDEADBEEF; MEM_RF_BUS rfrom_mem=1.
- ld.b, offset 3, rdata=0x80FF1234 -> final_result=0xFFFFFF80; ld.bu at the same offset -> 0x00000080; ld.h, offset 2 -> 0xFFFF80FF; ld.hu, offset 0 -> 0x00001234.
- ld.w with rdata=0x11111111 in the first cycle, then WB_allowin=0 for 3 cycles while rdata changes to 0x22222222 -> final_result stays 0x11111111 throughout and MEM_allowin=0.
- Add result 0x5, gr_we=1, dest=7 -> final_result=0x5, MEM_RF_BUS dest=7; the same payload with EXE_to_MEM_valid dropping afterwards -> dest field 0 once MEM_valid clears.
- Back-to-back loads every cycle with WB_allowin=1 -> each retires with its own first-cycle rdata, no bubbles, first_cycle stays 1.
- resetn low during a stalled load -> next cycle MEM_to_WB_valid=0, MEM_RF_BUS=0, MEM_allowin=1.
